// File: rtl/tra_bus_dispatch.sv
// Transmit-path bus dispatcher: raises a one-hot request to the selected CAN
// bus node, holds it until that node acks or a timeout expires, then pulses
// end_tra or tra_err back to the transmit controller.
module tra_bus_dispatch #(
  parameter int unsigned NUM_BUS     = 32,
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned TO_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_tra,
  input  logic [75:0]        data_tra_in,
  input  logic [4:0]         data_tra_select,
  input  logic [NUM_BUS-1:0] tra_ack,
  output logic [NUM_BUS-1:0] tra_req,
  output logic [75:0]        data_tra_out,
  output logic               busy,
  output logic               end_tra,
  output logic               tra_err,
  output logic [4:0]         err_bus_id,
  output logic               start_lost
);

  localparam int unsigned FRAME_W = 76;
  localparam int unsigned SEL_W   = 5;

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  state_t             state, state_nxt;
  logic [TO_W-1:0]    cnt, cnt_nxt;
  logic [SEL_W-1:0]   sel_reg, sel_nxt;
  logic [FRAME_W-1:0] data_nxt;
  logic               sel_in_valid;
  logic               ack_hit;

  // One-hot decode of a bus id; ids at or above NUM_BUS decode to all zeros.
  function automatic logic [NUM_BUS-1:0] bus_onehot(input logic [SEL_W-1:0] s);
    logic [NUM_BUS-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NUM_BUS; i++) begin
      r[i] = (32'(s) == i);
    end
    return r;
  endfunction

  assign sel_in_valid = (32'(data_tra_select) < NUM_BUS);
  // Only the ack of the addressed node counts; other bits are ignored.
  assign ack_hit      = |(tra_ack & bus_onehot(sel_reg));

  // Next-state, counter and capture logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = sel_reg;
    data_nxt  = data_tra_out;
    case (state)
      IDLE: begin
        if (start_tra) begin
          data_nxt  = data_tra_in;
          sel_nxt   = data_tra_select;
          cnt_nxt   = '0;
          state_nxt = sel_in_valid ? REQ : ERR;
        end
      end
      REQ: begin
        // Ack is checked first so it wins over a same-cycle timeout.
        if (ack_hit) begin
          state_nxt = DONE;
        end else if (cnt == TO_W'(TIMEOUT_CYC - 1)) begin
          state_nxt = ERR;
        end else begin
          cnt_nxt = cnt + TO_W'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, counter and captured select/frame registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      sel_reg      <= '0;
      data_tra_out <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      sel_reg      <= sel_nxt;
      data_tra_out <= data_nxt;
    end
  end

  // Registered status outputs, decoded from the upcoming state.
  always_ff @(posedge clk) begin
    if (rst) begin
      tra_req    <= '0;
      busy       <= 1'b0;
      end_tra    <= 1'b0;
      tra_err    <= 1'b0;
      err_bus_id <= '0;
      start_lost <= 1'b0;
    end else begin
      tra_req    <= (state_nxt == REQ) ? bus_onehot(sel_nxt) : '0;
      busy       <= (state_nxt != IDLE);
      end_tra    <= (state_nxt == DONE);
      tra_err    <= (state_nxt == ERR);
      if (state_nxt == ERR) begin
        err_bus_id <= sel_nxt;
      end
      if (start_tra && (state != IDLE)) begin
        start_lost <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tra_bus_dispatch.sv
// Bench for tra_bus_dispatch: table of transactions driven through a
// scoreboard, plus hand sequences for collision and mid-request reset.
module tb_tra_bus_dispatch;

  localparam int unsigned NB = 8;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_tra;
  logic [75:0]   data_tra_in;
  logic [4:0]    data_tra_select;
  logic [NB-1:0] tra_ack;
  logic [NB-1:0] tra_req;
  logic [75:0]   data_tra_out;
  logic          busy;
  logic          end_tra;
  logic          tra_err;
  logic [4:0]    err_bus_id;
  logic          start_lost;

  tra_bus_dispatch #(.NUM_BUS(NB), .TIMEOUT_CYC(TO), .TO_W(5)) dut (
    .clk(clk), .rst(rst), .start_tra(start_tra), .data_tra_in(data_tra_in),
    .data_tra_select(data_tra_select), .tra_ack(tra_ack), .tra_req(tra_req),
    .data_tra_out(data_tra_out), .busy(busy), .end_tra(end_tra),
    .tra_err(tra_err), .err_bus_id(err_bus_id), .start_lost(start_lost)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  sel;
    logic [75:0] data;
    int          ack_after;   // req cycles before ack is driven; -1 = never
    logic [4:0]  ack_bit;
    logic        exp_err;
    int          exp_req;     // cycles tra_req is expected high
  } vec_t;

  typedef struct {
    logic        err;
    logic [4:0]  sel;
    logic [75:0] data;
    int          req_cycles;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  vec_t vecs[7];
  int   total = 0;
  int   bad   = 0;
  int   req_cnt = 0;
  bit   idle_next = 1'b0;
  logic [NB-1:0] exp_oh;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: checks request shape and each completion pulse.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      req_cnt   = 0;
      idle_next = 1'b0;
    end else begin
      if (idle_next) begin
        check("busy_after_pulse", 128'(busy), 128'(0));
        idle_next = 1'b0;
      end
      if (tra_req != '0) begin
        req_cnt++;
        if (sb.size() == 0) begin
          check("req_unexpected", 128'(tra_req), 128'(0));
        end else begin
          exp_oh = NB'(1) << sb[0].sel;
          check("req_onehot", 128'(tra_req), 128'(exp_oh));
        end
      end
      if (end_tra || tra_err) begin
        check("busy_in_pulse", 128'(busy), 128'(1));
        if (sb.size() == 0) begin
          check("pulse_unexpected", 128'({end_tra, tra_err}), 128'(0));
        end else begin
          e = sb.pop_front();
          check("pulse_kind", 128'({end_tra, tra_err}), e.err ? 128'(2'b01) : 128'(2'b10));
          check("req_cycles", 128'(req_cnt), 128'(e.req_cycles));
          check("data_out", 128'(data_tra_out), 128'(e.data));
          if (e.err) check("err_bus_id", 128'(err_bus_id), 128'(e.sel));
        end
        req_cnt   = 0;
        idle_next = 1'b1;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 128'(busy), 128'(0));
  endtask

  task automatic run_txn(input vec_t v);
    exp_t x;
    @(negedge clk);
    start_tra       = 1'b1;
    data_tra_in     = v.data;
    data_tra_select = v.sel;
    x.err = v.exp_err; x.sel = v.sel; x.data = v.data; x.req_cycles = v.exp_req;
    sb.push_back(x);
    @(negedge clk);
    start_tra = 1'b0;
    if (v.ack_after >= 0) begin
      repeat (v.ack_after) @(negedge clk);
      tra_ack = NB'(1) << v.ack_bit;
      @(negedge clk);
      tra_ack = '0;
    end
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t x;
    // sel, data, ack_after, ack_bit, exp_err, exp_req
    vecs[0] = '{5'd5,  76'hABC_0500_0000_1234_5678,  9, 5'd5, 1'b0, 10}; // nominal
    vecs[1] = '{5'd3,  76'h123_4567_89AB_CDEF_0123, -1, 5'd0, 1'b1, 16}; // timeout
    vecs[2] = '{5'd2,  76'h0FE_DCBA_9876_5432_1000,  3, 5'd4, 1'b1, 16}; // wrong-bus ack
    vecs[3] = '{5'd2,  76'h555_AAAA_5555_AAAA_5555, 15, 5'd2, 1'b0, 16}; // ack/timeout race
    vecs[4] = '{5'd12, 76'h777_0000_1111_2222_3333, -1, 5'd0, 1'b1,  0}; // invalid select
    vecs[5] = '{5'd7,  76'h001_0002_0003_0004_0005,  0, 5'd7, 1'b0,  1}; // immediate ack
    vecs[6] = '{5'd0,  76'hFFF_FFFF_FFFF_FFFF_FFFE, 14, 5'd0, 1'b0, 15}; // ack one before limit

    rst = 1'b1; start_tra = 1'b0; data_tra_in = '0; data_tra_select = '0; tra_ack = '0;
    repeat (2) @(negedge clk);
    check("rst_tra_req",    128'(tra_req),      128'(0));
    check("rst_data_out",   128'(data_tra_out), 128'(0));
    check("rst_busy",       128'(busy),         128'(0));
    check("rst_end_tra",    128'(end_tra),      128'(0));
    check("rst_tra_err",    128'(tra_err),      128'(0));
    check("rst_err_bus_id", 128'(err_bus_id),   128'(0));
    check("rst_start_lost", 128'(start_lost),   128'(0));
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_txn(vecs[i]);

    @(negedge clk);
    check("sb_drained",      128'(sb.size()),    128'(0));
    check("err_id_sticky",   128'(err_bus_id),   128'(12));
    check("data_held",       128'(data_tra_out), 128'(76'hFFF_FFFF_FFFF_FFFF_FFFE));
    check("no_lost_yet",     128'(start_lost),   128'(0));

    // Collision: second start while requesting is dropped.
    start_tra = 1'b1; data_tra_select = 5'd1; data_tra_in = 76'h111_2222_3333_4444_5555;
    x.err = 1'b0; x.sel = 5'd1; x.data = 76'h111_2222_3333_4444_5555; x.req_cycles = 0;
    sb.push_back(x);
    @(negedge clk);
    data_tra_select = 5'd6; data_tra_in = 76'h999_8888_7777_6666_5555;
    @(negedge clk);
    start_tra = 1'b0;
    check("coll_start_lost", 128'(start_lost),   128'(1));
    check("coll_data_kept",  128'(data_tra_out), 128'(76'h111_2222_3333_4444_5555));
    check("coll_req",        128'(tra_req),      128'(8'h02));
    check("coll_busy",       128'(busy),         128'(1));

    // Reset in the middle of the request.
    rst = 1'b1;
    @(negedge clk);
    check("mrst_tra_req",    128'(tra_req),      128'(0));
    check("mrst_busy",       128'(busy),         128'(0));
    check("mrst_start_lost", 128'(start_lost),   128'(0));
    check("mrst_end_tra",    128'(end_tra),      128'(0));
    check("mrst_tra_err",    128'(tra_err),      128'(0));
    check("mrst_data_out",   128'(data_tra_out), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_idle",   128'(busy),         128'(0));
    check("post_rst_sb",     128'(sb.size()),    128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
